layer_instr_issuer: RTL and testbench

- Issues layer instructions to the CNN layer controller, one at a time.
- Buffers host-loaded 32-bit instructions in an internal FIFO.
- Drives each instruction on the controller's instruction input, then waits for the write-completion handshake (the controller's write_signal) before advancing.
- Sits between the host/config interface and the layer controller, ahead of the FC/conv and pooling datapaths.

---
 rtl/layer_instr_issuer.sv | 232 +++++++++++++++++++++++
 tb/tb_layer_instr_issuer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_instr_issuer.sv
// Buffers host instructions in a FIFO and issues them one at a time to the layer controller.
// Optional WAIT_DONE performance counters are enabled with `define ISSUE_PERF_CNT_EN.
module layer_instr_issuer #(
    parameter int                           INSTRUCTION_WIDTH = 32,
    parameter int                           DEPTH             = 16,
    parameter int                           TIMEOUT_CYCLES    = 4096,
    parameter logic [INSTRUCTION_WIDTH-1:0] POOL_OPCODE       = 32'hFFFF_FFFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    input  logic [INSTRUCTION_WIDTH-1:0]  load_data,
    output logic                          load_ready,
    input  logic                          start,
    input  logic                          flush,
    input  logic                          wr_done,
    output logic [INSTRUCTION_WIDTH-1:0]  instr_out,
    output logic                          instr_valid,
    output logic                          pool_flag,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic [15:0]                   issued_cnt,
`ifdef ISSUE_PERF_CNT_EN
    output logic [31:0]                   stall_cycles,
    output logic [15:0]                   max_wait,
`endif
    output logic [1:0]                    dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [INSTRUCTION_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]                  r_wr_ptr;
    logic [AW-1:0]                  r_rd_ptr;
    logic [CW-1:0]                  r_count;
    logic [INSTRUCTION_WIDTH-1:0]   r_instr_out;
    logic                           r_instr_valid;
    logic                           r_err;
    logic [15:0]                    r_issued;
    logic [TW-1:0]                  r_tmo_cnt;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_issue;
    logic                           w_done;
    logic                           w_to_err;
    logic                           w_tmo_hit;
    logic                           w_load_ready;

    assign w_load_ready = (r_count != FULL_CNT);
    // flush drops any word offered in the same cycle
    assign w_push    = load_valid && w_load_ready && !flush;
    assign w_pop     = w_issue;
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_next   = r_state;
        w_issue  = 1'b0;
        w_done   = 1'b0;
        w_to_err = 1'b0;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (r_count != '0)) begin
                        w_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT;
                end
                S_WAIT: begin
                    // completion beats a timeout expiring in the same cycle
                    if (wr_done) begin
                        if (r_count == '0) begin
                            w_next = S_IDLE;
                            w_done = 1'b1;
                        end else begin
                            w_next = S_ISSUE;
                        end
                    end else if (w_tmo_hit) begin
                        w_next   = S_ERROR;
                        w_to_err = 1'b1;
                    end
                end
                S_ERROR: begin
                    w_next = S_ERROR;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // instr_out is held between issues and across flush; the controller samples it when ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_out   <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= w_issue;
            if (w_issue) begin
                r_instr_out <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_issued  <= '0;
            r_tmo_cnt <= '0;
        end else if (flush) begin
            r_err     <= 1'b0;
            r_issued  <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (w_to_err) begin
                r_err <= 1'b1;
            end
            if (w_issue) begin
                r_issued  <= r_issued + 16'd1;
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT) && (TIMEOUT_CYCLES != 0) && !w_tmo_hit) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] r_stall;
    logic [15:0] r_cur_wait;
    logic [15:0] r_max_wait;
    logic [15:0] w_wait_len;

    // length of the current WAIT_DONE stretch including this cycle, saturating
    assign w_wait_len = (r_cur_wait != 16'hFFFF) ? r_cur_wait + 16'd1 : r_cur_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall    <= '0;
            r_cur_wait <= '0;
            r_max_wait <= '0;
        end else if (flush) begin
            r_stall    <= '0;
            r_cur_wait <= '0;
            r_max_wait <= '0;
        end else if (r_state == S_WAIT) begin
            if (r_stall != 32'hFFFF_FFFF) begin
                r_stall <= r_stall + 32'd1;
            end
            r_cur_wait <= w_wait_len;
            if (w_wait_len > r_max_wait) begin
                r_max_wait <= w_wait_len;
            end
        end else if (w_issue) begin
            r_cur_wait <= '0;
        end
    end

    assign stall_cycles = r_stall;
    assign max_wait     = r_max_wait;
`endif

    assign load_ready  = w_load_ready;
    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign pool_flag   = (r_instr_out == POOL_OPCODE);
    assign busy        = (r_state != S_IDLE);
    assign done        = w_done;
    assign err         = r_err;
    assign fifo_count  = r_count;
    assign issued_cnt  = r_issued;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_layer_instr_issuer.sv
// Bench for layer_instr_issuer: directed steps plus random batches against a queue-based model.
module tb_layer_instr_issuer;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  localparam int CW    = 5;
  localparam logic [W-1:0] POOL = 32'hFFFF_FFFF;

  logic clk, rst_n, load_valid, load_ready, start, flush, wr_done;
  logic [W-1:0] load_data, instr_out;
  logic instr_valid, pool_flag, busy, done, err;
  logic [CW-1:0] fifo_count;
  logic [15:0] issued_cnt;
  logic [1:0] dbg_state;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] max_wait;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_mode = 0;        // 0: finish after wait_q length, 1: wr_done held high
  int done_cnt = 0;
  int valid_cnt = 0;
  int exp_done_cyc = -1;
  int mdl_issued = 0;
  logic [W-1:0] exp_q[$];   // words expected on instr_out, in order
  int exp_vcyc_q[$];        // cycle each instr_valid is expected in
  int wait_q[$];            // WAIT_DONE length per issued word, 0 = never complete
  logic [W-1:0] mdl_fifo[$];
  int lens[$];
  logic [W-1:0] mon_w;
  int mon_c;

  layer_instr_issuer #(
    .INSTRUCTION_WIDTH(W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .POOL_OPCODE(POOL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .flush(flush), .wr_done(wr_done),
    .instr_out(instr_out), .instr_valid(instr_valid), .pool_flag(pool_flag),
    .busy(busy), .done(done), .err(err), .fifo_count(fifo_count),
    .issued_cnt(issued_cnt),
`ifdef ISSUE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .max_wait(max_wait),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset-independent cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // controller model: raises wr_done on the L-th WAIT_DONE cycle after each instr_valid
  initial begin
    int k;
    int len;
    wr_done = 1'b0;
    k = 0;
    len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        k = 0;
        wr_done = 1'b0;
      end else if (resp_mode == 1) begin
        wr_done = 1'b1;
      end else begin
        if (instr_valid) begin
          k = 1;
          len = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end else if (k > 0) begin
          k++;
        end
        wr_done = (k > 0) && (k == len);
        if (wr_done) k = 0;
      end
    end
  end

  // scoreboard: every issue and every done pulse is checked against the expected queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_w = exp_q.pop_front();
          mon_c = exp_vcyc_q.pop_front();
          check("instr_out", instr_out, mon_w);
          check("pool_flag", {31'd0, pool_flag}, {31'd0, mon_w == POOL});
          check("valid_cycle", cyc, mon_c);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_cycle", cyc, exp_done_cyc);
      end
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data = d;
    if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(d);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic clear_expect();
    exp_q.delete();
    exp_vcyc_q.delete();
    wait_q.delete();
    exp_done_cyc = -1;
  endtask

  // Issues the whole model FIFO with per-word wait lengths from lens[]; each
  // word occupies one ISSUE cycle plus its WAIT_DONE cycles.
  task automatic run_batch(input bit extra_start);
    int s, t, len, n, d0, k;
    n = mdl_fifo.size();
    d0 = done_cnt;
    s = cyc;
    t = s + 2;
    for (int i = 0; i < n; i++) begin
      len = (resp_mode == 1) ? 1 : lens[i];
      exp_q.push_back(mdl_fifo[i]);
      exp_vcyc_q.push_back(t);
      if (resp_mode == 0) wait_q.push_back(len);
      if (i == n - 1) exp_done_cyc = t + len - 1;
      t += len + 1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (extra_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    k = 0;
    while (busy !== 1'b0 && k < (t - s + 20)) begin
      tick();
      k++;
    end
    check("back_to_idle", {31'd0, busy}, 32'd0);
    check("pending_issues", exp_q.size(), 32'd0);
    check("done_pulses", done_cnt - d0, 32'd1);
    mdl_issued += n;
    check("issued_cnt", issued_cnt, mdl_issued[15:0]);
    check("fifo_empty", fifo_count, 32'd0);
    clear_expect();
    mdl_fifo.delete();
    lens.delete();
  endtask

  initial begin
    logic [W-1:0] w;
    int s, n, d0, v0;
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    start = 1'b0;
    flush = 1'b0;
    tick(2);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pool_flag", {31'd0, pool_flag}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_fifo_count", fifo_count, 32'd0);
    check("rst_issued", issued_cnt, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // three-word program with a pooling word in the middle, wr_done 3 cycles after each issue
    push_word(32'h0000_0001);
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    check("fifo_count_3", fifo_count, 32'd3);
    lens = '{4, 4, 4};
    v0 = valid_cnt;
    run_batch(1'b1);
    check("three_valids", valid_cnt - v0, 32'd3);
    check("instr_out_held", instr_out, 32'h0000_0002);
    check("pool_flag_after", {31'd0, pool_flag}, 32'd0);

    // start with an empty FIFO is ignored
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("empty_start_busy", {31'd0, busy}, 32'd0);
    check("empty_start_done", done_cnt - d0, 32'd0);

    // random batches; wait length 8 meets the last timeout cycle and must still complete
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        w = ($urandom_range(0, 3) == 0) ? POOL : $urandom;
        push_word(w);
        lens.push_back($urandom_range(1, TMO));
      end
      check("rand_fifo_count", fifo_count, n);
      run_batch(r[0]);
    end

    // overflow: DEPTH+1 words offered back to back, the last is dropped
    load_valid = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      load_data = 32'h0000_0100 + i;
      check("load_ready_fill", {31'd0, load_ready}, {31'd0, mdl_fifo.size() != DEPTH});
      if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(load_data);
      tick();
    end
    load_valid = 1'b0;
    check("full_count", fifo_count, DEPTH);
    check("full_ready", {31'd0, load_ready}, 32'd0);
    resp_mode = 1;
    run_batch(1'b0);

    // wr_done held high with 4 words: issue every 2 cycles, done 8 cycles after start
    for (int i = 0; i < 4; i++) push_word($urandom);
    run_batch(1'b0);
    resp_mode = 0;
    tick(2);

    // timeout: no completion for 8 WAIT_DONE cycles
    w = $urandom;
    push_word(w);
    mdl_fifo.delete();
    s = cyc;
    exp_q.push_back(w);
    exp_vcyc_q.push_back(s + 2);
    wait_q.push_back(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(8);
    check("tmo_last_wait_err", {31'd0, err}, 32'd0);
    check("tmo_last_wait_state", dbg_state, 32'd2);
    tick();
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_state_error", dbg_state, 32'd3);
    check("tmo_busy", {31'd0, busy}, 32'd1);
    tick(5);
    check("err_sticky", {31'd0, err}, 32'd1);
    check("err_instr_hold", instr_out, w);
    mdl_issued++;
    check("tmo_issued", issued_cnt, mdl_issued[15:0]);
    push_word(32'hDEAD_0001);
    mdl_fifo.delete();
    check("err_push_count", fifo_count, 32'd1);
    flush = 1'b1;
    load_valid = 1'b1;
    load_data = 32'hDEAD_0002;
    tick();
    flush = 1'b0;
    load_valid = 1'b0;
    mdl_issued = 0;
    check("flush_err", {31'd0, err}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_count", fifo_count, 32'd0);
    check("flush_issued", issued_cnt, 32'd0);
    check("flush_instr_hold", instr_out, w);
    clear_expect();
    tick(2);

    // asynchronous reset while waiting with two words still queued
    w = 32'h0000_00A5;
    push_word(w);
    push_word(32'h0000_00A6);
    push_word(32'h0000_00A7);
    s = cyc;
    exp_q.push_back(w);
    exp_vcyc_q.push_back(s + 2);
    wait_q.push_back(0);
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    check("pre_rst_state", dbg_state, 32'd2);
    check("pre_rst_count", fifo_count, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_instr_out", instr_out, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_count", fifo_count, 32'd0);
    check("arst_ready", {31'd0, load_ready}, 32'd1);
    check("arst_issued", issued_cnt, 32'd0);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    clear_expect();
    mdl_fifo.delete();
    mdl_issued = 0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("arst_no_done", done_cnt - d0, 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);

`ifdef ISSUE_PERF_CNT_EN
    // wait lengths 5 then 2
    push_word(32'h0000_0011);
    push_word(32'h0000_0012);
    lens = '{5, 2};
    run_batch(1'b0);
    check("stall_cycles", stall_cycles, 32'd7);
    check("max_wait", max_wait, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_flush_stall", stall_cycles, 32'd0);
    check("perf_flush_max", max_wait, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
